// File: rtl/rice_core_data_memory.sv
// rice_core_data_memory: word-array load/store responder with a
// one-entry registered response stage and valid/ready backpressure.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_request_valid/o_request_ready   request handshake
//   i_access_type, i_access_mode      NONE/STORE/LOAD, B/BU/H/HU/W
//   i_address, i_write_data           byte address, right-aligned data
//   o_response_valid/i_response_ready response handshake
//   o_read_data, o_error              extended load data, reject flag
// Option: RICE_CORE_DATA_MEMORY_ALIGNMENT_CHECK_EN turns misaligned
// H/HU/W into errors; otherwise low address bits are forced to zero.
module rice_core_data_memory #(
    parameter int DEPTH = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_request_valid,
    output logic        o_request_ready,
    input  logic [1:0]  i_access_type,
    input  logic [2:0]  i_access_mode,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    output logic        o_response_valid,
    input  logic        i_response_ready,
    output logic [31:0] o_read_data,
    output logic        o_error
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_error_q, rsp_error_d;

    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic [1:0]    lane;
    logic          is_store, is_load, type_bad;
    logic          is_half, is_word;
    logic          mode_ok, in_range, align_err, error;
    logic [31:0]   rd_word, shifted, load_data;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          accept, wr_en;

    // Ready only depends on the response slot, never on the request.
    assign o_request_ready = !rsp_valid_q || i_response_ready;
    assign accept = i_request_valid && o_request_ready && !i_rst;

    always_comb begin
        word_idx = i_address[2 +: AW];
        off      = i_address[1:0];
        is_store = (i_access_type == 2'd1);
        is_load  = (i_access_type == 2'd2);
        type_bad = (i_access_type == 2'd3);
        is_half  = (i_access_mode[1:0] == 2'b01);
        is_word  = (i_access_mode[1:0] == 2'b10);

        case (i_access_mode)
            3'b000, 3'b100,
            3'b001, 3'b101,
            3'b010:  mode_ok = 1'b1;
            default: mode_ok = 1'b0;
        endcase

        // Any address bit above the word index puts us past 4*DEPTH.
        in_range = ((i_address >> (AW + 2)) == 32'd0);

`ifdef RICE_CORE_DATA_MEMORY_ALIGNMENT_CHECK_EN
        align_err = (is_half && off[0]) ||
                    (is_word && (off != 2'b00));
        lane      = off;
`else
        align_err = 1'b0;
        lane      = is_word ? 2'b00 :
                    is_half ? {off[1], 1'b0} : off;
`endif

        error = type_bad ||
                ((is_load || is_store) &&
                 (!mode_ok || !in_range ||
                  (is_store && i_access_mode[2]) ||
                  align_err));

        rd_word = mem_q[word_idx];
        shifted = rd_word >> {lane, 3'b000};

        case (i_access_mode[1:0])
            2'b00: load_data = i_access_mode[2] ?
                       {24'd0, shifted[7:0]} :
                       {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = i_access_mode[2] ?
                       {16'd0, shifted[15:0]} :
                       {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase

        // Replicate the narrow data across lanes; the byte enables
        // pick which lanes actually land in the word.
        case (i_access_mode[1:0])
            2'b00: begin
                wr_data = {4{i_write_data[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            2'b01: begin
                wr_data = {2{i_write_data[15:0]}};
                wr_be   = 4'b0011 << lane;
            end
            default: begin
                wr_data = i_write_data;
                wr_be   = 4'b1111;
            end
        endcase

        wr_en = accept && is_store && !error;

        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = error;
            rsp_data_d  = (is_load && !error) ? load_data : 32'd0;
        end else if (i_response_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Array is deliberately not reset; contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign o_response_valid = rsp_valid_q;
    assign o_read_data      = rsp_data_q;
    assign o_error          = rsp_error_q;

endmodule

// File: tb/tb_rice_core_data_memory.sv
// tb_rice_core_data_memory: directed and randomized checks of the
// data memory against a byte-addressed reference model.
module tb_rice_core_data_memory;
    localparam int DEPTH = 1024;

    logic        i_clk;
    logic        i_rst;
    logic        i_request_valid;
    logic        o_request_ready;
    logic [1:0]  i_access_type;
    logic [2:0]  i_access_mode;
    logic [31:0] i_address;
    logic [31:0] i_write_data;
    logic        o_response_valid;
    logic        i_response_ready;
    logic [31:0] o_read_data;
    logic        o_error;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mb [0:4*DEPTH-1];
    logic [31:0] exp_rd;
    logic        exp_err;

    rice_core_data_memory #(.DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_request_valid  (i_request_valid),
        .o_request_ready  (o_request_ready),
        .i_access_type    (i_access_type),
        .i_access_mode    (i_access_mode),
        .i_address        (i_address),
        .i_write_data     (i_write_data),
        .o_response_valid (o_response_valid),
        .i_response_ready (i_response_ready),
        .o_read_data      (o_read_data),
        .o_error          (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: byte-addressed memory, access size from the mode.
    function automatic void model(input logic [1:0] t, input logic [2:0] m,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic e);
        int n;
        logic [31:0] ea;
        logic [63:0] v;
        rd = 32'd0;
        e = 1'b0;
        if (t == 2'd0) return;
        if (t == 2'd3) begin
            e = 1'b1;
            return;
        end
        if (!(m inside {3'd0, 3'd4, 3'd1, 3'd5, 3'd2})) e = 1'b1;
        if (a >= 32'(4 * DEPTH)) e = 1'b1;
        if (t == 2'd1 && m[2]) e = 1'b1;
        n = (m[1:0] == 2'b00) ? 1 : (m[1:0] == 2'b01) ? 2 : 4;
        ea = a;
        if ((ea % n) != 0) begin
`ifdef RICE_CORE_DATA_MEMORY_ALIGNMENT_CHECK_EN
            e = 1'b1;
`else
            ea = ea - (ea % n);
`endif
        end
        if (e) return;
        if (t == 2'd1) begin
            for (int i = 0; i < n; i++) mb[ea + i] = wd[8*i +: 8];
        end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = v | (64'(mb[ea + i]) << (8 * i));
            if (!m[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            rd = v[31:0];
        end
    endfunction

    // Presents one request that is expected to be accepted at the next edge.
    task automatic issue(input logic [1:0] t, input logic [2:0] m,
                         input logic [31:0] a, input logic [31:0] wd);
        i_request_valid = 1'b1;
        i_access_type = t;
        i_access_mode = m;
        i_address = a;
        i_write_data = wd;
        model(t, m, a, wd, exp_rd, exp_err);
        @(posedge i_clk);
        #1;
        i_request_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            checks++;
            if (o_response_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", o_response_valid); end
            checks++;
            if (o_read_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", o_read_data); end
            checks++;
            if (o_error !== 1'b0) begin failures++; $display("FAIL rst_error got=%0b exp=0", o_error); end
            checks++;
            if (o_request_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", o_request_ready); end
        end
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_response_valid !== 1'b0 || o_request_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_rst valid=%0b ready=%0b exp 0/1", o_response_valid, o_request_ready);
        end
    endtask

    task automatic test_store_load();
        checks++;
        if (o_response_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", o_response_valid); end
        issue(2'd1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++;
        if (o_response_valid !== 1'b1 || o_read_data !== 32'd0 || o_error !== 1'b0) begin
            failures++;
            $display("FAIL st_w v=%0b d=%h e=%0b exp 1/00000000/0", o_response_valid, o_read_data, o_error);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_response_valid !== 1'b0) begin failures++; $display("FAIL consumed_valid got=%0b exp=0", o_response_valid); end
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        checks++;
        if (o_response_valid !== 1'b1 || o_read_data !== 32'hDEADBEEF || o_error !== 1'b0) begin
            failures++;
            $display("FAIL ld_w v=%0b d=%h e=%0b exp 1/deadbeef/0", o_response_valid, o_read_data, o_error);
        end
    endtask

    task automatic test_subword();
        logic [2:0]  modes [4];
        logic [31:0] addrs [4];
        logic [31:0] exps [4];
        modes = '{3'b000, 3'b100, 3'b001, 3'b101};
        addrs = '{32'h13, 32'h13, 32'h10, 32'h12};
        exps = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 4; i++) begin
            issue(2'd2, modes[i], addrs[i], 32'd0);
            checks++;
            if (o_read_data !== exps[i] || o_error !== 1'b0) begin
                failures++;
                $display("FAIL ld_sub%0d d=%h e=%0b exp %h/0", i, o_read_data, o_error, exps[i]);
            end
        end
        issue(2'd1, 3'b000, 32'h11, 32'hAAAAAA12);
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        checks++;
        if (o_read_data !== 32'hDEAD12EF) begin failures++; $display("FAIL st_b got=%h exp=dead12ef", o_read_data); end
        issue(2'd1, 3'b001, 32'h12, 32'hBBBB5678);
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        checks++;
        if (o_read_data !== 32'h567812EF) begin failures++; $display("FAIL st_h got=%h exp=567812ef", o_read_data); end
    endtask

    task automatic test_stall();
        i_response_ready = 1'b0;
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        i_request_valid = 1'b1;
        i_access_type = 2'd2;
        i_access_mode = 3'b000;
        i_address = 32'h10;
        i_write_data = 32'd0;
        repeat (3) begin
            checks++;
            if (o_request_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0b exp=0", o_request_ready); end
            checks++;
            if (o_response_valid !== 1'b1 || o_read_data !== 32'h567812EF || o_error !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold v=%0b d=%h e=%0b exp 1/567812ef/0", o_response_valid, o_read_data, o_error);
            end
            @(posedge i_clk);
            #1;
        end
        i_response_ready = 1'b1;
        #1;
        checks++;
        if (o_request_ready !== 1'b1) begin failures++; $display("FAIL unstall_ready got=%0b exp=1", o_request_ready); end
        model(2'd2, 3'b000, 32'h10, 32'd0, exp_rd, exp_err);
        @(posedge i_clk);
        #1;
        i_request_valid = 1'b0;
        checks++;
        if (o_response_valid !== 1'b1 || o_read_data !== 32'hFFFFFFEF || o_error !== 1'b0) begin
            failures++;
            $display("FAIL swap_rsp v=%0b d=%h e=%0b exp 1/ffffffef/0", o_response_valid, o_read_data, o_error);
        end
    endtask

    task automatic test_errors();
        issue(2'd1, 3'b101, 32'h10, 32'hFFFFFFFF);
        checks++;
        if (o_error !== 1'b1 || o_read_data !== 32'd0) begin failures++; $display("FAIL st_hu e=%0b d=%h exp 1/0", o_error, o_read_data); end
        issue(2'd1, 3'b011, 32'h10, 32'h11111111);
        checks++;
        if (o_error !== 1'b1) begin failures++; $display("FAIL bad_mode e=%0b exp=1", o_error); end
        issue(2'd3, 3'b010, 32'h10, 32'h22222222);
        checks++;
        if (o_error !== 1'b1) begin failures++; $display("FAIL bad_type e=%0b exp=1", o_error); end
        issue(2'd1, 3'b010, 32'(4 * DEPTH) + 32'h10, 32'h33333333);
        checks++;
        if (o_error !== 1'b1) begin failures++; $display("FAIL oor_st e=%0b exp=1", o_error); end
        issue(2'd2, 3'b010, 32'(4 * DEPTH), 32'd0);
        checks++;
        if (o_error !== 1'b1 || o_read_data !== 32'd0) begin failures++; $display("FAIL oor_ld e=%0b d=%h exp 1/0", o_error, o_read_data); end
        issue(2'd0, 3'b111, 32'hFFFFFFFF, 32'h44444444);
        checks++;
        if (o_error !== 1'b0 || o_read_data !== 32'd0) begin failures++; $display("FAIL none e=%0b d=%h exp 0/0", o_error, o_read_data); end
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        checks++;
        if (o_read_data !== 32'h567812EF || o_error !== 1'b0) begin failures++; $display("FAIL no_write d=%h exp=567812ef", o_read_data); end
        issue(2'd2, 3'b010, 32'h11, 32'd0);
        checks++;
`ifdef RICE_CORE_DATA_MEMORY_ALIGNMENT_CHECK_EN
        if (o_error !== 1'b1 || o_read_data !== 32'd0) begin failures++; $display("FAIL misalign e=%0b d=%h exp 1/0", o_error, o_read_data); end
`else
        if (o_error !== 1'b0 || o_read_data !== 32'h567812EF) begin failures++; $display("FAIL misalign e=%0b d=%h exp 0/567812ef", o_error, o_read_data); end
`endif
    endtask

    task automatic test_reset_mid();
        i_response_ready = 1'b0;
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        i_rst = 1'b1;
        i_request_valid = 1'b1;
        i_access_type = 2'd1;
        i_access_mode = 3'b010;
        i_address = 32'h10;
        i_write_data = 32'h0BADF00D;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_response_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", o_response_valid); end
        checks++;
        if (o_request_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%0b exp=1", o_request_ready); end
        i_response_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_request_valid = 1'b0;
        repeat (2) begin
            @(posedge i_clk);
            #1;
            checks++;
            if (o_response_valid !== 1'b0) begin failures++; $display("FAIL dropped_rsp got=%0b exp=0", o_response_valid); end
        end
        issue(2'd2, 3'b010, 32'h10, 32'd0);
        checks++;
        if (o_read_data !== 32'h567812EF) begin failures++; $display("FAIL rst_keep d=%h exp=567812ef", o_read_data); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] legal [5];
        logic [1:0] t;
        logic [2:0] m;
        logic [31:0] a;
        int r;
        legal = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        for (int w = 0; w < 16; w++) begin
            issue(2'd1, 3'b010, 32'(w * 4), $urandom);
            checks++;
            if (o_response_valid !== 1'b1 || o_error !== 1'b0) begin
                failures++;
                $display("FAIL init%0d v=%0b e=%0b exp 1/0", w, o_response_valid, o_error);
            end
        end
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            t = (r < 45) ? 2'd2 : (r < 85) ? 2'd1 : (r < 93) ? 2'd0 : 2'd3;
            m = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
            a = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH) + 32'($urandom_range(0, 255))
                                            : 32'($urandom_range(0, 63));
            checks++;
            if (o_request_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%0b exp=1", k, o_request_ready); end
            issue(t, m, a, $urandom);
            checks++;
            if (o_response_valid !== 1'b1 || o_read_data !== exp_rd || o_error !== exp_err) begin
                failures++;
                $display("FAIL b2b%0d t=%0d m=%0b a=%h v=%0b d=%h e=%0b exp 1/%h/%0b",
                         k, t, m, a, o_response_valid, o_read_data, o_error, exp_rd, exp_err);
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_request_valid = 1'b0;
        i_access_type = 2'd0;
        i_access_mode = 3'd0;
        i_address = 32'd0;
        i_write_data = 32'd0;
        i_response_ready = 1'b1;
        exp_rd = 32'd0;
        exp_err = 1'b0;
        #1;
        test_reset();
        test_store_load();
        test_subword();
        test_stall();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rice_core_data_memory.md
# rice_core_data_memory

Data-memory responder on the far end of the core's load/store port. It accepts one memory access per handshake, encoded with the core's access type (NONE/STORE/LOAD) and access mode (B/BU/H/HU/W). Stores are byte-lane merged into an internal word array. Loads return data shifted to bit 0 and sign- or zero-extended. Every accepted request gets exactly one response, in order, through a one-entry registered response stage with backpressure.

## Interface
- DEPTH: 1024. Number of 32-bit words; power of two, ≥2.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_request_valid  in  1  request present.
- o_request_ready  out  1  request accepted when valid && ready.
- i_access_type  in  2  0 NONE, 1 STORE, 2 LOAD; 3 is illegal.
- i_access_mode  in  3  B=000, BU=100, H=001, HU=101, W=010; other codes are illegal.
- i_address  in  32  byte address.
- i_write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_response_valid  out  1  response present.
- i_response_ready  in  1  response consumed when valid && ready.
- o_read_data  out  32  load result (extended); 0 for non-load or error.
- o_error  out  1  access rejected; no state change.

## Operation
- Word index = i_address[2+:$clog2(DEPTH)]. Byte offset = i_address[1:0].
- Out of range: i_address ≥ 4*DEPTH → error.
- Legality:
  - Illegal type → error.
  - Illegal mode on LOAD or STORE → error.
  - STORE with BU/HU → error.
  - NONE ignores mode and address: response with error=0, data=0.
- Alignment (see Configuration): H/HU need offset[0]=0; W needs offset=00.
- STORE, legal:
  - B writes byte lane offset with i_write_data[7:0].
  - H writes lanes offset and offset+1 with [15:0].
  - W writes all four lanes.
  - Other lanes are unchanged. Response data=0, error=0.
- LOAD, legal:
  - Lane(s) are selected from the array word as it stands at the accept edge.
  - B/H sign-extend from bit 7/15. BU/HU zero-extend.
- Error → no array write; o_read_data=0, o_error=1.
- The array is not reset; contents survive i_rst.

## Timing
- o_request_ready = !o_response_valid || i_response_ready (combinational, no dependence on i_request_valid).
- Accept edge N: the array write (STORE) and the response register load both happen at edge N. o_response_valid=1 from cycle N+1.
- Latency 1 cycle; throughput 1 access/cycle while i_response_ready=1.
- Response stall: o_response_valid, o_read_data and o_error hold stable until consumed.
- Simultaneous consume + accept in the same cycle: the new response replaces the old one, and valid stays 1.
- Read-after-write: a LOAD accepted at N+1 after a STORE at N to the same word sees the stored value.
- Reset values: o_response_valid=0, o_read_data=0, o_error=0. o_request_ready=1 during and after reset.
- i_rst mid-operation: the pending response is dropped. A request presented in a reset cycle is not accepted and causes no write.
- Request inputs are sampled only on the accept edge.

## Configuration
- RICE_CORE_DATA_MEMORY_ALIGNMENT_CHECK_EN defined:
  - A misaligned H/HU/W is an error response with no write.
- Not defined:
  - Misalignment is never an error. The offending low address bits are forced to 0 (H ignores bit 0, W ignores bits 1:0), and the access proceeds on the aligned location.
- Range, type and mode checks are always present.

## Test plan
- Reset, then STORE W 0xDEADBEEF @0x10, then LOAD W @0x10 → response 1 cycle after each accept; data 0x00000000 then 0xDEADBEEF, error 0.
- After that store:
  - LOAD B @0x13 → 0xFFFFFFDE.
  - LOAD BU @0x13 → 0x000000DE.
  - LOAD H @0x10 → 0xFFFFBEEF.
  - LOAD HU @0x12 → 0x0000DEAD.
- STORE B 0x12 @0x11, then LOAD W @0x10 → 0xDEAD12EF. STORE H 0x5678 @0x12 → next LOAD W → 0x567812EF.
- Hold i_response_ready=0 for 3 cycles with a LOAD pending:
  - o_request_ready=0; outputs stable.
  - Back-to-back requests with ready=1 → one response per cycle, in order.
- Errors, each with no write (checked by a following LOAD W of the target word):
  - STORE HU → error=1.
  - Mode 011 → error=1.
  - Type 3 → error=1.
  - Address 4*DEPTH → error=1.
  - LOAD W @0x11 → error=1 with the macro defined; 0x567812EF without it.
- Assert i_rst while a response is stalled → o_response_valid=0 the next cycle. The array keeps 0x567812EF @0x10, and no response is emitted for the dropped request.
